loadblock: RTL
==============

# loadblock

Load-data alignment unit for the RV32IMC data path, the read-side counterpart of the store path. It sits between the MEM-stage address/funct3 and the synchronous, word-wide data BRAM. It issues the word read, then extracts the addressed byte, halfword or word and sign- or zero-extends it. Loads that cross a word boundary take two BRAM reads, with a pipeline stall between them.

## Interface
- DM_ADDR_W, 10: data-memory word-address width. Memory size is 2^DM_ADDR_W words.

- clk  input  1  system clock, rising edge
- nrst  input  1  asynchronous, active-low reset
- is_ltype  input  1  load request valid this cycle
- addr  input  32  effective byte address of the load
- load_select  input  3  funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Codes 011, 110 and 111 are treated as lw.
- dm_rdata  input  32  BRAM read data, valid one cycle after dm_addr is sampled; byte 0 is on bits [7:0]
- dm_addr  output  DM_ADDR_W  BRAM word address, combinational
- ld_stall  output  1  upstream must hold; no new request is accepted
- ld_valid  output  1  registered one-cycle pulse: ld_data is the result
- ld_data  output  32  registered aligned and extended load result

## Operation
- States:
  - IDLE
  - WAIT1: first word returning
  - WAIT2: second word returning
- Accept condition: is_ltype=1 while in IDLE, or while in WAIT1 with a non-crossing captured load.
  - is_ltype is ignored in every other case.
  - On accept, capture byte offset addr[1:0], load_select and word address addr[DM_ADDR_W+1:2], then go to WAIT1.
- dm_addr:
  - addr[DM_ADDR_W+1:2] while accepting is possible.
  - Captured word +1 in WAIT1 when the captured load is crossing; the increment wraps modulo 2^DM_ADDR_W.
  - Otherwise, hold the last value.
- Crossing load: lw with offset≠0, or lh/lhu with offset=3. lb/lbu never cross.
- WAIT1, non-crossing:
  - At the clock edge, ld_data gets the selected lanes of dm_rdata, extended; ld_valid gets 1.
  - Next state: WAIT1 if a new request is accepted, otherwise IDLE.
- WAIT1, crossing:
  - At the edge, dm_rdata goes into the hold register; next state is WAIT2.
  - ld_valid gets 0.
- WAIT2:
  - At the edge, the result is assembled: low bytes are the upper bytes of the hold register starting at the offset; high bytes are the low bytes of dm_rdata.
  - The result is extended, ld_valid gets 1, and the state goes to IDLE.
- Extension:
  - lb: sign from bit 7 of the selected byte. lh: sign from bit 15 of the halfword.
  - lbu/lhu: zero-extend.
  - lw: no extension.
- ld_stall = (state=WAIT1 and crossing) or state=WAIT2. It is combinational from registered state only, with no path from is_ltype.
- ld_valid is 0 in every cycle that does not directly follow a completing edge.
- ld_data holds its value when ld_valid=0.

## Timing
- Reset (nrst=0, asynchronous):
  - state=IDLE, ld_valid=0, ld_data=0, hold register=0, captured fields=0.
  - ld_stall=0, dm_addr=0 while in reset.
- Reset mid-operation (WAIT1 or WAIT2): the load is abandoned and no ld_valid is produced. After release, operation resumes in IDLE.
- Non-crossing load sampled at edge E0: ld_valid=1 in the cycle after E1. ld_stall stays 0.
- Crossing load sampled at E0:
  - ld_stall=1 from E0 to E2.
  - dm_addr=W+1 during E0–E1.
  - ld_valid=1 in the cycle after E2.
- Throughput:
  - Back-to-back non-crossing loads: one per cycle.
  - A crossing load costs one extra cycle.
  - A request presented in the cycle ld_valid pulses after a crossing load is accepted.

## Test plan
Preload word 4 = 0x80FF7F01 and word 5 = 0x44332211.

- lw addr 0x10 -> dm_addr=4, ld_data=0x80FF7F01, ld_valid one cycle after E1, ld_stall never 1.
- lb 0x13 -> 0xFFFFFF80; lbu 0x13 -> 0x00000080; lh 0x12 -> 0xFFFF80FF; lhu 0x12 -> 0x000080FF; lb 0x11 -> 0x0000007F. Issue all five back-to-back: five consecutive ld_valid pulses.
- lw 0x11 -> dm_addr 4 then 5, ld_stall high 2 cycles, ld_data=0x1180FF7F. lh 0x13 -> 0x00001180.
- Wrap: lw at byte address 0xFFE with word 0x3FF=0xAABBCCDD and word 0x000=0x11223344 -> dm_addr 0x3FF then 0x000, ld_data=0x3344AABB.
- Reset mid-op: nrst low during WAIT2 of lw 0x11 -> outputs reset immediately, no ld_valid. A following lw 0x14 returns 0x44332211.
- is_ltype held high throughout a crossing load -> the request is not re-captured while ld_stall=1. A new request is accepted only in the ld_valid cycle.

Source files
------------

// File: rtl/loadblock.sv
// Load alignment unit: issues the BRAM word read(s) for a load, then extracts
// and sign/zero-extends the addressed byte, halfword or word.
module loadblock #(
    parameter int unsigned DM_ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 is_ltype,
    input  logic [31:0]          addr,
    input  logic [2:0]           load_select,
    input  logic [31:0]          dm_rdata,
    output logic [DM_ADDR_W-1:0] dm_addr,
    output logic                 ld_stall,
    output logic                 ld_valid,
    output logic [31:0]          ld_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [1:0]             cap_off;
    logic [2:0]             cap_sel;
    logic [DM_ADDR_W-1:0]   cap_word;
    logic [DM_ADDR_W-1:0]   dm_addr_q;
    logic [31:0]            hold;

    logic                   cross_c;
    logic                   open_c;
    logic                   accept_c;
    logic                   complete_c;
    logic [63:0]            pair_c;
    logic [63:0]            shifted_c;
    logic [31:0]            word_c;
    logic [31:0]            result_c;
    logic                   unused_addr_c;

    // Address bits above the memory size do not select anything.
    assign unused_addr_c = ^addr[31:DM_ADDR_W+2];

    // Crossing classification of the captured load; unused funct3 codes act as lw.
    always_comb begin
        cross_c = 1'b0;
        case (cap_sel)
            3'b000, 3'b100: cross_c = 1'b0;
            3'b001, 3'b101: cross_c = (cap_off == 2'd3);
            default:        cross_c = (cap_off != 2'd0);
        endcase
    end

    assign open_c   = (state == IDLE) || ((state == WAIT1) && !cross_c);
    assign accept_c = is_ltype && open_c;

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c) state_nxt = WAIT1;
            end
            WAIT1: begin
                if (cross_c)       state_nxt = WAIT2;
                else if (accept_c) state_nxt = WAIT1;
                else               state_nxt = IDLE;
            end
            WAIT2:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: BRAM address, stall, and the aligned/extended result.
    always_comb begin
        dm_addr    = dm_addr_q;
        ld_stall   = 1'b0;
        complete_c = 1'b0;
        pair_c     = {dm_rdata, dm_rdata};
        shifted_c  = '0;
        word_c     = '0;
        result_c   = '0;

        if (!nrst) begin
            dm_addr = '0;
        end else if (open_c) begin
            dm_addr = addr[DM_ADDR_W+1:2];
        end else if (state == WAIT1) begin
            dm_addr = cap_word + DM_ADDR_W'(1);
        end

        ld_stall   = ((state == WAIT1) && cross_c) || (state == WAIT2);
        complete_c = ((state == WAIT1) && !cross_c) || (state == WAIT2);

        // A non-crossing load rotates within one word; a crossing one spans hold:rdata.
        if (state == WAIT2) pair_c = {dm_rdata, hold};
        shifted_c = pair_c >> {cap_off, 3'b000};
        word_c    = shifted_c[31:0];

        case (cap_sel)
            3'b000:  result_c = {{24{word_c[7]}}, word_c[7:0]};
            3'b100:  result_c = {24'd0, word_c[7:0]};
            3'b001:  result_c = {{16{word_c[15]}}, word_c[15:0]};
            3'b101:  result_c = {16'd0, word_c[15:0]};
            default: result_c = word_c;
        endcase
    end

    // Captured request fields, hold register and registered result.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cap_off   <= '0;
            cap_sel   <= '0;
            cap_word  <= '0;
            hold      <= '0;
            dm_addr_q <= '0;
            ld_valid  <= 1'b0;
            ld_data   <= '0;
        end else begin
            dm_addr_q <= dm_addr;
            ld_valid  <= complete_c;
            if (accept_c) begin
                cap_off  <= addr[1:0];
                cap_sel  <= load_select;
                cap_word <= addr[DM_ADDR_W+1:2];
            end
            if ((state == WAIT1) && cross_c) hold <= dm_rdata;
            if (complete_c) ld_data <= result_c;
        end
    end

endmodule
